// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores with a fixed
// response latency. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic [31:0] mem [DEPTH];

    logic          oob, err, access;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   word, shw, wd, ld;

    assign idx    = addr_q[AW+1:2];
    assign oob    = |addr_q[31:AW+2];
    assign access = (state == WAIT) && (cnt == 2'd0);
    assign word   = mem[idx];

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis = ((size_q == 2'b01) && addr_q[0]) ||
                 ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    assign err = oob || (size_q == 2'b11) || mis;
`else
    assign err = oob || (size_q == 2'b11);
`endif

    // Lane select: misaligned low bits are dropped so halves/words stay naturally aligned
    always_comb begin
        lane = addr_q[1:0];
        be   = 4'b0001 << addr_q[1:0];
        wd   = {4{wdata_q[7:0]}};
        case (size_q)
            2'b01: begin
                lane = {addr_q[1], 1'b0};
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wd   = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                lane = 2'b00;
                be   = 4'b1111;
                wd   = wdata_q;
            end
            default: ;
        endcase
        shw = word >> {lane, 3'b000};
        case (size_q)
            2'b00:   ld = uns_q ? {24'b0, shw[7:0]}  : {{24{shw[7]}}, shw[7:0]};
            2'b01:   ld = uns_q ? {16'b0, shw[15:0]} : {{16{shw[15]}}, shw[15:0]};
            default: ld = word;
        endcase
    end

    // Contents survive reset; an aborted request never reaches access since state resets to IDLE
    always_ff @(posedge clk) begin
        if (access && we_q && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[idx][b*8 +: 8] <= wd[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        state     <= WAIT;
                        cnt       <= 2'(LATENCY - 1);
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= (we_q || err) ? 32'd0 : ld;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: instance 0 at LATENCY=1, instance 1 at LATENCY=3.
module tb_dmem_ctrl;
    logic        clk, rst_n;
    logic        rv[2], rw[2], ru[2];
    logic [1:0]  rs[2];
    logic [31:0] ra[2], rwd[2];
    logic        rr[2], pv[2], pe[2];
    logic [31:0] pd[2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        time         t;
        int          lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    dmem_ctrl #(.DEPTH(64), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(rw[0]),
        .req_size(rs[0]), .req_unsigned(ru[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .resp_valid(pv[0]), .resp_rdata(pd[0]), .resp_err(pe[0]));

    dmem_ctrl #(.DEPTH(64), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(rw[1]),
        .req_size(rs[1]), .req_unsigned(ru[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .resp_valid(pv[1]), .resp_rdata(pd[1]), .resp_err(pe[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input int i);
        exp_t e;
        int   n;
        n = (i == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            chk($sformatf("spurious_resp%0d", i), 32'd1, 32'd0);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata%0d", i), pd[i], e.d);
        chk($sformatf("err%0d", i), {31'd0, pe[i]}, {31'd0, e.e});
        chk($sformatf("latency%0d", i), 32'(($time - e.t - 5) / 10), 32'(e.lat));
    endtask

    always @(negedge clk) begin
        if (pv[0]) pop_chk(0);
        if (pv[1]) pop_chk(1);
    end

    // Issue one request; the expected response is queued at the acceptance edge.
    task automatic xact(input int i, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wdat,
                        input logic [31:0] ed, input logic ee,
                        input bit hold, input bit push, output time tacc);
        exp_t e;
        int   n;
        @(negedge clk);
        rw[i] = we; rs[i] = sz; ru[i] = uns; ra[i] = a; rwd[i] = wdat; rv[i] = 1'b1;
        n = 0;
        while (!rr[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
            rv[i] = 1'b0;
            tacc = 0;
            return;
        end
        @(posedge clk);
        tacc  = $time;
        e.d   = ed;
        e.e   = ee;
        e.t   = tacc;
        e.lat = (i == 0) ? 1 : 3;
        if (push) begin
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        if (!hold) begin
            @(negedge clk);
            rv[i] = 1'b0; rw[i] = 1'($urandom); ra[i] = $urandom; rwd[i] = $urandom;
        end
    endtask

    task automatic op(input int i, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wdat,
                      input logic [31:0] ed, input logic ee);
        time t;
        xact(i, we, sz, uns, a, wdat, ed, ee, 1'b0, 1'b1, t);
    endtask

    initial begin
        time t1, t2;
        int  n;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 0; rw[i] = 0; ru[i] = 0; rs[i] = 2'b00; ra[i] = 0; rwd[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_ready%0d", i), {31'd0, rr[i]}, 32'd0);
            chk($sformatf("rst_valid%0d", i), {31'd0, pv[i]}, 32'd0);
            chk($sformatf("rst_rdata%0d", i), pd[i], 32'd0);
            chk($sformatf("rst_err%0d", i), {31'd0, pe[i]}, 32'd0);
        end
        rst_n = 1'b1;

        // LATENCY=1: lane selection, extension, range and size errors
        op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        op(0, 1, 2'b00, 0, 32'h11, 32'hAAAAAA7F, 32'h0, 0);
        op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0);
        op(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
        op(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0);
        op(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
        op(0, 0, 2'b01, 1, 32'h12, 32'h0, 32'h0000DEAD, 0);
        op(0, 0, 2'b00, 0, 32'h11, 32'h0, 32'h0000007F, 0);
        op(0, 0, 2'b10, 1, 32'h10, 32'h0, 32'hDEAD7FEF, 0);
        op(0, 1, 2'b10, 0, 32'h14, 32'h11223344, 32'h0, 0);
        op(0, 1, 2'b01, 0, 32'h16, 32'h9999BEEF, 32'h0, 0);
        op(0, 0, 2'b10, 0, 32'h14, 32'h0, 32'hBEEF3344, 0);
        op(0, 0, 2'b01, 0, 32'h14, 32'h0, 32'h00003344, 0);
        op(0, 1, 2'b10, 0, 32'h0, 32'h01020304, 32'h0, 0);
        op(0, 1, 2'b10, 0, 32'h100, 32'hCAFEF00D, 32'h0, 1);
        op(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'h01020304, 0);
        op(0, 0, 2'b10, 0, 32'h80000000, 32'h0, 32'h0, 1);
        op(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
        op(0, 1, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
        op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        op(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'h0, 1);
        op(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1);
        op(0, 1, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
        op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0);
`else
        op(0, 0, 2'b10, 0, 32'h12, 32'h0, 32'hDEAD7FEF, 0);
        op(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'hFFFFDEAD, 0);
        op(0, 0, 2'b01, 1, 32'h15, 32'h0, 32'h00003344, 0);
`endif

        // LATENCY=3: back-to-back throughput with req_valid held high
        op(1, 1, 2'b10, 0, 32'h20, 32'h0BADF00D, 32'h0, 0);
        xact(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0BADF00D, 0, 1'b1, 1'b1, t1);
        xact(1, 0, 2'b00, 1, 32'h22, 32'h0, 32'h000000AD, 0, 1'b0, 1'b1, t2);
        chk("accept_gap", 32'((t2 - t1) / 10), 32'd5);

        // Reset pulse mid-WAIT aborts a store with no response
        xact(1, 1, 2'b10, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 0, 1'b0, 1'b0, t1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!rr[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_after_reset", {31'd0, rr[1]}, 32'd1);
        repeat (5) @(negedge clk);
        op(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0BADF00D, 0);
        op(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0);

        repeat (10) @(negedge clk);
        chk("pending0", 32'(q0.size()), 32'd0);
        chk("pending1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
